// File: rtl/alu_cmd_pkg.sv
// Shared ALU command types: opcode enum, command record and default sizing.
package alu_cmd_pkg;

    localparam int unsigned ALU_DATA_WIDTH     = 8;
    localparam int unsigned ALU_CMD_FIFO_DEPTH = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_SHL = 4'h5,
        OP_SHR = 4'h6,
        OP_NOP = 4'hF
    } alu_op_t;

    typedef struct packed {
        alu_op_t                   op;
        logic [ALU_DATA_WIDTH-1:0] a;
        logic [ALU_DATA_WIDTH-1:0] b;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo_mem.sv
// Command storage: DEPTH x alu_cmd_t registers, one write port, async read port.
module alu_cmd_fifo_mem
    import alu_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = ALU_CMD_FIFO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  alu_cmd_t                 wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output alu_cmd_t                 rdata_o
);

    alu_cmd_t mem_q [DEPTH];

    // Contents are deliberately never reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_cmd_fifo.sv
// First-word fall-through command FIFO between the ALU driver and the ALU.
// Optional: define ALU_CMD_FIFO_FLUSH_EN to add a synchronous FLUSH input.
module alu_cmd_fifo
    import alu_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int unsigned DEPTH      = ALU_CMD_FIFO_DEPTH
) (
    input  logic                    CLK,
    input  logic                    RESET,
`ifdef ALU_CMD_FIFO_FLUSH_EN
    input  logic                    FLUSH,
`endif
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [3:0]              IN_OP,
    input  logic [DATA_WIDTH-1:0]   IN_A,
    input  logic [DATA_WIDTH-1:0]   IN_B,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [3:0]              OUT_OP,
    output logic [DATA_WIDTH-1:0]   OUT_A,
    output logic [DATA_WIDTH-1:0]   OUT_B,
    output logic [$clog2(DEPTH):0]  COUNT,
    output logic                    FULL,
    output logic                    EMPTY
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic     flush;
    logic     push;
    logic     pop;
    alu_cmd_t wdata;
    alu_cmd_t rdata;

`ifdef ALU_CMD_FIFO_FLUSH_EN
    assign flush = FLUSH;
`else
    assign flush = 1'b0;
`endif

    assign FULL      = (count_q == CNT_W'(DEPTH));
    assign EMPTY     = (count_q == '0);
    assign IN_READY  = !FULL;
    assign OUT_VALID = !EMPTY;
    assign COUNT     = count_q;

    assign push = IN_VALID && IN_READY;
    assign pop  = OUT_VALID && OUT_READY;

    assign wdata.op = alu_op_t'(IN_OP);
    assign wdata.a  = IN_A;
    assign wdata.b  = IN_B;

    assign OUT_OP = rdata.op;
    assign OUT_A  = rdata.a;
    assign OUT_B  = rdata.b;

    // Power-of-two DEPTH lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    alu_cmd_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (push && !flush && !RESET),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

endmodule
